// File: rtl/time_pkg.sv
`default_nettype none
// ============================================================================
// Module      : time_pkg
// Description : Shared types for the receiver-domain timing blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package time_pkg;

  // Interval meter control states
  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FIRST = 2'd1,
    ST_MEASURE    = 2'd2,
    ST_DONE       = 2'd3
  } interval_state_t;

  // True while a measurement is in progress (armed or counting)
  function automatic logic is_active(interval_state_t st);
    return (st == ST_WAIT_FIRST) || (st == ST_MEASURE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/edge_detect.sv
`default_nettype none
// ============================================================================
// Module      : edge_detect
// Description : Rising-edge detector for the interval meter event input.
//               Macro INTERVAL_METER_SYNC_EN inserts a 2-flop synchronizer
//               ahead of the sample register for asynchronous pins.
// Revision    : 1.0 - initial release
// ============================================================================
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic event_i,
  output logic rise_o
);

  logic event_in;
  logic event_s_q;
  logic event_p_q;

`ifdef INTERVAL_METER_SYNC_EN
  logic sync1_q;
  logic sync2_q;

  // Two-flop synchronizer for an event pin not related to clk
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= event_i;
      sync2_q <= sync1_q;
    end
  end

  assign event_in = sync2_q;
`else
  assign event_in = event_i;
`endif

  // Sample and one-cycle history; runs in every state of the meter
  always_ff @(posedge clk) begin
    if (rst) begin
      event_s_q <= 1'b0;
      event_p_q <= 1'b0;
    end else begin
      event_s_q <= event_in;
      event_p_q <= event_s_q;
    end
  end

  assign rise_o = event_s_q & ~event_p_q;

endmodule
`default_nettype wire

// File: rtl/interval_meter.sv
`default_nettype none
// ============================================================================
// Module      : interval_meter
// Description : Counts en_i ticks between two consecutive rising edges of
//               event_i after arming, and presents the saturating count on a
//               valid/ready handshake. INTERVAL_METER_SYNC_EN (see
//               edge_detect) adds a 2-flop synchronizer on event_i.
// Revision    : 1.0 - initial release
// ============================================================================
module interval_meter
  import time_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic          event_i,
  input  logic          en_i,
  input  logic          clr_i,
  output logic [DW-1:0] result_o,
  output logic          overflow_o,
  output logic          valid_o,
  input  logic          ready_i,
  output logic          active_o
);

  localparam logic [DW-1:0] ALL_ONES = {DW{1'b1}};

  interval_state_t state_q;
  logic [DW-1:0]   count_q;
  logic [DW-1:0]   count_d;
  logic [DW-1:0]   result_q;
  logic            overflow_q;
  logic            valid_q;
  logic            active_q;
  logic            rise;

  edge_detect u_edge (
    .clk     (clk),
    .rst     (rst),
    .event_i (event_i),
    .rise_o  (rise)
  );

  assign count_d = count_q + DW'(1);

  // Control FSM with counter and registered result/status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
      active_q   <= 1'b0;
    end else if (clr_i) begin
      // Abort wins over everything; the last result stays visible
      state_q  <= ST_IDLE;
      count_q  <= '0;
      valid_q  <= 1'b0;
      active_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          count_q <= '0;
          if (start_i) begin
            state_q  <= ST_WAIT_FIRST;
            active_q <= 1'b1;
          end
        end
        ST_WAIT_FIRST: begin
          count_q <= '0;
          if (rise) begin
            state_q <= ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          if (en_i && (count_q == ALL_ONES)) begin
            // Saturation takes precedence over a coincident closing edge
            state_q    <= ST_DONE;
            result_q   <= ALL_ONES;
            overflow_q <= 1'b1;
            valid_q    <= 1'b1;
            active_q   <= 1'b0;
          end else if (rise) begin
            // Closing edge: the tick in this same cycle is not counted
            state_q    <= ST_DONE;
            result_q   <= count_q;
            overflow_q <= 1'b0;
            valid_q    <= 1'b1;
            active_q   <= 1'b0;
          end else if (en_i) begin
            count_q <= count_d;
          end
        end
        ST_DONE: begin
          if (ready_i) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          valid_q  <= 1'b0;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  assign result_o   = result_q;
  assign overflow_o = overflow_q;
  assign valid_o    = valid_q;
  assign active_o   = active_q;

endmodule
`default_nettype wire

// File: doc/interval_meter.md
# interval_meter

Measures the number of `en_i` time-unit ticks between two consecutive rising edges of an event input, after being armed, and returns the result through a valid/ready handshake. It is the measuring counterpart to the loadable timer: the timer turns a count into a done event, and this block turns a pair of events into a count. It sits in the receiver time domain and is fed by the same tick strobe as the timers. Its consumer is the downstream timing-analysis logic.

## Interface
- `DW`, default 16: width of the tick counter and the result.
- `clk`  in  1: clock.
- `rst`  in  1: synchronous, active-high reset.
- `start_i`  in  1: arm a measurement; honoured only in IDLE.
- `event_i`  in  1: level event input; rising edges open and close the interval.
- `en_i`  in  1: time-unit strobe; one pulse counts one unit.
- `clr_i`  in  1: abort any measurement or pending result.
- `result_o`  out  DW: measured tick count.
- `overflow_o`  out  1: result saturated; qualified by `valid_o`.
- `valid_o`  out  1: result available.
- `ready_i`  in  1: consumer accepts the result.
- `active_o`  out  1: high in WAIT_FIRST or MEASURE.

## Operation
- State machine: IDLE, WAIT_FIRST, MEASURE, DONE.
- IDLE:
  - `start_i` → WAIT_FIRST on the next cycle.
  - Count cleared to 0.
- WAIT_FIRST:
  - A detected rising edge → MEASURE.
  - Count cleared to 0.
  - `en_i` is ignored.
- MEASURE:
  - Each `en_i` increments the count.
  - A detected rising edge → DONE. `result_o` takes the count as it was before that cycle; an `en_i` in the closing-edge cycle is not counted.
  - An `en_i` with the count at all-ones → DONE with `overflow_o`=1 and `result_o`=all-ones.
  - Edge and overflow in the same cycle: overflow wins, and `overflow_o`=1.
- DONE:
  - `valid_o`=1; `result_o` and `overflow_o` are held stable.
  - `valid_o && ready_i` → IDLE.
  - `start_i` is ignored until the block is back in IDLE.
  - Rising edges on `event_i` are ignored.
- `clr_i`: from any state → IDLE on the next cycle. It has priority over edge, overflow, handshake and `start_i`. `result_o` keeps its last value; `valid_o` drops.
- Edge detection:
  - `event_s` is the registered sample of `event_i`; `event_p` is `event_s` delayed by one cycle.
  - rise = `event_s & ~event_p`.
  - Edge history keeps running in every state, so a level already high at arm time does not produce an edge.
- Counter is DW bits, unsigned, saturating; it never wraps.

## Timing
- Reset values: all outputs 0, state IDLE, `event_s`/`event_p` 0.
- `start_i` at cycle N: `active_o`=1 at N+1.
- Edge latency: `event_i` rising at cycle N (low at N-1) is acted on at N+1, with the state change visible at N+2.
- Closing edge: `valid_o`=1 one cycle after the rise-detect cycle.
- The result is accepted in the cycle `valid_o && ready_i`; `valid_o`=0 on the next cycle.
- Minimum arm-to-arm spacing is 1 cycle after acceptance, since IDLE accepts `start_i` in its first cycle.

## Configuration
- `INTERVAL_METER_SYNC_EN`:
  - Defined: `event_i` passes through a 2-flop synchronizer before `event_s`. Edge latency grows by 2 cycles; use this for asynchronous pins.
  - Undefined: `event_i` is assumed synchronous to `clk`, and the latency is as stated under Timing.

## Structure
- Shared package `time_pkg`: `interval_state_t` enum, covering IDLE, WAIT_FIRST, MEASURE and DONE.
- One sub-module, `edge_detect`:
  - Optional synchronizer under the same macro, plus the `event_s`/`event_p` registers.
  - Outputs a single-cycle rise pulse.
- The top level holds the FSM, the counter and the result/overflow registers.

## Test plan
- Basic measurement: reset, arm, rise `event_i`, pulse `en_i` 5 times, rise again, `ready_i`=1 → `result_o`=5, `overflow_o`=0, one-cycle `valid_o`.
- Coincident tick: `en_i` held at 1 continuously, edges 10 cycles apart → `result_o`=9, because the closing-edge tick is not counted.
- Overflow: DW=4, continuous `en_i`, no closing edge → DONE with `result_o`=15 and `overflow_o`=1 on the 16th tick.
- Backpressure: `ready_i`=0 for 20 cycles in DONE with extra edges and `start_i` pulses → `result_o` stable, `valid_o` held, no re-arm; `ready_i`=1 → IDLE.
- Abort and reset: `clr_i` in MEASURE and again in DONE → IDLE next cycle with `valid_o`=0. `rst` mid-MEASURE → all outputs 0.
- Level at arm: `event_i` already high when armed → no edge until a low-then-high transition. With `INTERVAL_METER_SYNC_EN` defined, edge latency is 2 cycles longer.
